// File: rtl/data_mem_ws.sv
// Byte-addressable RV32 data memory with req/ready handshake and WAIT_CYCLES wait states.
// Supports byte/half/word loads (sign or zero extended) and stores, with misalignment errors.
module data_mem_ws #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wrdata,
  output logic [31:0]       rddata,
  output logic              ready,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [31:0]       wd_q;
  logic              uns_q;
  logic              err_q;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  logic              misaligned;
  logic              do_access;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       load_data;

  assign misaligned = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00));

  assign do_access = (state == S_WAIT) && (cnt == 4'd0);

  // Aligned accesses never cross the array top, so plain ADDR_W-bit adds suffice.
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);
  assign b0 = mem[addr_q];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    load_data = {b3, b2, b1, b0};
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   load_data = uns_q ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: load_data = {b3, b2, b1, b0};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req) state_next = misaligned ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      we_q   <= 1'b0;
      size_q <= 2'b00;
      wd_q   <= 32'h0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      rddata <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q <= addr;
            we_q   <= we;
            size_q <= size;
            wd_q   <= wrdata;
            uns_q  <= unsigned_ld;
            err_q  <= misaligned;
            cnt    <= WAIT_CNT;
            if (misaligned) rddata <= 32'h0;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (!we_q)  rddata <= load_data;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; a reset mid-WAIT forces IDLE so do_access never fires.
  always_ff @(posedge clk) begin
    if (do_access && we_q) begin
      mem[addr_q] <= wd_q[7:0];
      if (size_q != 2'b00) mem[a1] <= wd_q[15:8];
      if (size_q == 2'b10) begin
        mem[a2] <= wd_q[23:16];
        mem[a3] <= wd_q[31:24];
      end
    end
  end

  assign ready = (state == S_RESP);
  assign err   = ready & err_q;

endmodule

// File: doc/data_mem_ws.md
Name: data_mem_ws

Overview:
Parametrised byte-addressable data memory for the RISC-V core with a req/ready handshake and a configurable number of wait states. It supports RV32 byte, halfword and word accesses, with load sign or zero extension and misalignment detection. It sits between the core's load/store unit and the data array, and stalls the core until `ready` is asserted.

Parameters:
ADDR_W, 10, byte-address width; array holds 2**ADDR_W bytes
WAIT_CYCLES, 2, wait states between acceptance and completion (0..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset; asynchronous and active-low
req  in  1  access request, sampled only in IDLE
we  in  1  1 = store, 0 = load (latched with req)
size  in  2  00 byte, 01 half, 10 word, 11 illegal
unsigned_ld  in  1  1 = zero-extend byte/half loads (LBU/LHU)
addr  in  ADDR_W  byte address
wrdata  in  32  store data; byte/half taken from low bits
rddata  out  32  load result, registered; valid when ready=1
ready  out  1  one-cycle completion pulse
err  out  1  misaligned/illegal flag, valid with ready

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, ready=0, err=0, rddata=0, wait counter=0.
  - Memory array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE, req=1 at an edge: latch addr, we, size, wrdata and unsigned_ld; compute the misalignment check.
  - Check fails if: size=01 with addr[0]=1; size=10 with addr[1:0]!=00; size=11.
  - Fail: go to RESP with err pending. No array access, no wait states.
  - Pass: load counter with WAIT_CYCLES, go to WAIT.
- IDLE, req=0: stay in IDLE.
- WAIT: decrement the counter each cycle. At the edge where the counter equals 0, perform the access and go to RESP.
  - With WAIT_CYCLES=0, WAIT lasts exactly one cycle.
- Access, little-endian, at the WAIT->RESP edge:
  - Store byte: mem[a]=wd[7:0].
  - Store half: mem[a]=wd[7:0], mem[a+1]=wd[15:8].
  - Store word: bytes a..a+3 = wd[7:0], wd[15:8], wd[23:16], wd[31:24].
  - Load: assemble the same byte lanes into rddata. Byte/half are sign-extended from bit 7/15 unless unsigned_ld=1, in which case zero-extended.
  - A store leaves rddata unchanged.
- RESP: ready=1 for exactly one cycle, then return to IDLE unconditionally.
  - err=1 only in a RESP entered from a failed check. On error rddata=0.
  - err=0 whenever ready=0.
- Latency: request accepted at edge t; ready is high in the cycle after edge t+WAIT_CYCLES+1. Error responses come one cycle after acceptance.
- Throughput: one access per WAIT_CYCLES+3 cycles. The earliest next acceptance is the edge after RESP.
- req is ignored in WAIT and RESP; inputs may change freely after acceptance.
- rddata holds its last value until the next load completion or error.
- Aligned accesses never cross the top of the array, so there is no wrap-around.
- Reset mid-WAIT aborts the access: a pending store is never written, and no ready is produced.

Test Plan:
- Reset: hold rst_n=0 while req=1 -> ready=0, err=0, rddata=0; release rst_n -> FSM in IDLE, no spurious ready.
- Word round trip, WAIT_CYCLES=2: store 0xDEADBEEF at 0x010, accepted at edge t -> ready pulses after edge t+3. Word load of 0x010 -> rddata=0xDEADBEEF, err=0.
- Sub-word loads after the above:
  - LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE.
  - LH 0x010 -> 0xFFFFBEEF; LHU 0x010 -> 0x0000BEEF.
- Half store 0x1234 at 0x012, then word load of 0x010 -> 0x1234BEEF (upper half replaced, lower half untouched).
- Misaligned access:
  - Word store at 0x011 -> ready+err one cycle after acceptance, rddata=0; a later word load of 0x010 still returns 0x1234BEEF.
  - size=11 -> err=1.
- Busy and reset handling:
  - Toggle req and change addr during WAIT -> exactly one ready pulse; the second request is not serviced.
  - Assert rst_n=0 mid-WAIT of a store of 0xAAAAAAAA to 0x020 -> after reset, a load of 0x020 returns the prior contents.
